// File: rtl/pipe_pkg.sv
// Shared types and helpers for the EX->MEM writeback pipeline stage.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef struct packed {
    logic                  wen;
    logic [DEF_ADDR_W-1:0] waddr;
    logic [DEF_DATA_W-1:0] wdata;
  } wb_bundle_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // A write to register 0 is architecturally a no-op, so it can be dropped at capture.
  function automatic logic capture_wen(input logic wen, input logic addr_is_zero,
                                       input logic zero_squash);
    return wen & ~(zero_squash & addr_is_zero);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// Valid-qualified writeback payload register; flush drops only the valid bit.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_wen,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_valid,
  output logic              o_wen,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [DATA_W-1:0] o_wdata
);

  logic              r_valid;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  // Slot state: reset clears everything, flush beats load, load beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= {ADDR_W{1'b0}};
      r_wdata <= {DATA_W{1'b0}};
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_wen   <= i_wen;
      r_waddr <= i_waddr;
      r_wdata <= i_wdata;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_wen   = r_wen;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/ex_mem_pipe.sv
// EX->MEM pipeline stage for the writeback bundle: valid/ready handshake,
// synchronous flush, optional two-entry skid buffer.
module ex_mem_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SKID        = 1,
  parameter int ZERO_SQUASH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic              up_wen_i,
  input  logic [ADDR_W-1:0] up_waddr_i,
  input  logic [DATA_W-1:0] up_wdata_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic              dn_wen_o,
  output logic [ADDR_W-1:0] dn_waddr_o,
  output logic [DATA_W-1:0] dn_wdata_o
);

  logic              w_cap_wen;
  logic              w_up_fire;
  logic              w_dn_fire;
  logic              w_m_load;
  logic              w_m_clear;
  logic              w_m_wen_d;
  logic [ADDR_W-1:0] w_m_waddr_d;
  logic [DATA_W-1:0] w_m_wdata_d;
  logic              w_m_valid;
  logic              w_m_wen;
  logic [ADDR_W-1:0] w_m_waddr;
  logic [DATA_W-1:0] w_m_wdata;

  assign w_cap_wen = capture_wen(up_wen_i, (up_waddr_i == {ADDR_W{1'b0}}), (ZERO_SQUASH != 0));
  assign w_up_fire = up_valid_i & up_ready_o;
  assign w_dn_fire = w_m_valid & dn_ready_i;

  pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_m (
    .clk     (clk),
    .rst     (rst),
    .i_flush (flush_i),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_wen   (w_m_wen_d),
    .i_waddr (w_m_waddr_d),
    .i_wdata (w_m_wdata_d),
    .o_valid (w_m_valid),
    .o_wen   (w_m_wen),
    .o_waddr (w_m_waddr),
    .o_wdata (w_m_wdata)
  );

  generate
    if (SKID != 0) begin : g_skid
      skid_state_e       r_state;
      logic              w_s_load;
      logic              w_s_clear;
      logic              w_m_from_s;
      logic              w_m_ld;
      logic              w_m_clr;
      logic              w_s_valid;
      logic              w_s_wen;
      logic [ADDR_W-1:0] w_s_waddr;
      logic [DATA_W-1:0] w_s_wdata;

      pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_slot_s (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush_i),
        .i_load  (w_s_load),
        .i_clear (w_s_clear),
        .i_wen   (w_cap_wen),
        .i_waddr (up_waddr_i),
        .i_wdata (up_wdata_i),
        .o_valid (w_s_valid),
        .o_wen   (w_s_wen),
        .o_waddr (w_s_waddr),
        .o_wdata (w_s_wdata)
      );

      // Slot load/clear strobes decoded from the occupancy state and both handshakes.
      always_comb begin
        w_m_ld     = 1'b0;
        w_m_clr    = 1'b0;
        w_s_load   = 1'b0;
        w_s_clear  = 1'b0;
        w_m_from_s = 1'b0;
        case (r_state)
          EMPTY: begin
            w_m_ld = w_up_fire;
          end
          ONE: begin
            if (w_up_fire & w_dn_fire) begin
              w_m_ld = 1'b1;
            end else if (w_up_fire) begin
              w_s_load = 1'b1;
            end else if (w_dn_fire) begin
              w_m_clr = 1'b1;
            end else begin
              w_m_ld = 1'b0;
            end
          end
          TWO: begin
            if (w_dn_fire) begin
              w_m_ld     = 1'b1;
              w_m_from_s = 1'b1;
              w_s_clear  = 1'b1;
            end else begin
              w_m_ld = 1'b0;
            end
          end
          default: begin
            w_m_ld = 1'b0;
          end
        endcase
      end

      // Occupancy state machine.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state <= EMPTY;
        end else if (flush_i) begin
          r_state <= EMPTY;
        end else begin
          case (r_state)
            EMPTY:   if (w_up_fire) r_state <= ONE;
            ONE:     if (w_up_fire & ~w_dn_fire) r_state <= TWO;
                     else if (~w_up_fire & w_dn_fire) r_state <= EMPTY;
            TWO:     if (w_dn_fire) r_state <= ONE;
            default: r_state <= EMPTY;
          endcase
        end
      end

      // Ready comes straight off the skid valid flop, so dn_ready_i never reaches it.
      assign up_ready_o  = ~w_s_valid;
      assign w_m_load    = w_m_ld;
      assign w_m_clear   = w_m_clr;
      assign w_m_wen_d   = w_m_from_s ? w_s_wen   : w_cap_wen;
      assign w_m_waddr_d = w_m_from_s ? w_s_waddr : up_waddr_i;
      assign w_m_wdata_d = w_m_from_s ? w_s_wdata : up_wdata_i;
    end else begin : g_single
      assign up_ready_o  = ~w_m_valid | dn_ready_i;
      assign w_m_load    = w_up_fire;
      assign w_m_clear   = w_dn_fire & ~w_up_fire;
      assign w_m_wen_d   = w_cap_wen;
      assign w_m_waddr_d = up_waddr_i;
      assign w_m_wdata_d = up_wdata_i;
    end
  endgenerate

  assign dn_valid_o = w_m_valid;
  assign dn_wen_o   = w_m_valid & w_m_wen;
  assign dn_waddr_o = w_m_waddr;
  assign dn_wdata_o = w_m_wdata;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: skid (A), skid without zero squash (B), single entry (C).
module tb_ex_mem_pipe;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic a_flush, a_uv, a_wen, a_dr, a_ur, a_dv, a_dwen;
  logic [4:0] a_waddr, a_dwaddr;
  logic [31:0] a_wdata, a_dwdata;
  logic b_flush, b_uv, b_wen, b_dr, b_ur, b_dv, b_dwen;
  logic [4:0] b_waddr, b_dwaddr;
  logic [31:0] b_wdata, b_dwdata;
  logic c_flush, c_uv, c_wen, c_dr, c_ur, c_dv, c_dwen;
  logic [4:0] c_waddr, c_dwaddr;
  logic [31:0] c_wdata, c_dwdata;

  int n_pass = 0;
  int n_total = 0;
  wb_bundle_t q_a[$];
  wb_bundle_t q_c[$];
  wb_bundle_t e_a, e_c;

  ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .SKID(1), .ZERO_SQUASH(1)) u_dut_a (
    .clk(clk), .rst(rst), .flush_i(a_flush), .up_valid_i(a_uv), .up_ready_o(a_ur),
    .up_wen_i(a_wen), .up_waddr_i(a_waddr), .up_wdata_i(a_wdata), .dn_valid_o(a_dv),
    .dn_ready_i(a_dr), .dn_wen_o(a_dwen), .dn_waddr_o(a_dwaddr), .dn_wdata_o(a_dwdata));

  ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .SKID(1), .ZERO_SQUASH(0)) u_dut_b (
    .clk(clk), .rst(rst), .flush_i(b_flush), .up_valid_i(b_uv), .up_ready_o(b_ur),
    .up_wen_i(b_wen), .up_waddr_i(b_waddr), .up_wdata_i(b_wdata), .dn_valid_o(b_dv),
    .dn_ready_i(b_dr), .dn_wen_o(b_dwen), .dn_waddr_o(b_dwaddr), .dn_wdata_o(b_dwdata));

  ex_mem_pipe #(.DATA_W(32), .ADDR_W(5), .SKID(0), .ZERO_SQUASH(1)) u_dut_c (
    .clk(clk), .rst(rst), .flush_i(c_flush), .up_valid_i(c_uv), .up_ready_o(c_ur),
    .up_wen_i(c_wen), .up_waddr_i(c_waddr), .up_wdata_i(c_wdata), .dn_valid_o(c_dv),
    .dn_ready_i(c_dr), .dn_wen_o(c_dwen), .dn_waddr_o(c_dwaddr), .dn_wdata_o(c_dwdata));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic wb_bundle_t model(input logic wen, input logic [4:0] waddr,
                                       input logic [31:0] wdata);
    wb_bundle_t e;
    e.wen   = wen & (waddr != 5'd0);
    e.waddr = waddr;
    e.wdata = wdata;
    return e;
  endfunction

  // Monitors: every delivered entry must match the oldest accepted one.
  always @(negedge clk) begin
    if (!rst && !a_flush && a_dv && a_dr) begin
      if (q_a.size() == 0) begin
        n_total++;
        $display("FAIL mon_a: got unexpected entry %0h, expected none", a_dwdata);
      end else begin
        e_a = q_a.pop_front();
        chk("mon_a", {26'd0, a_dwen, a_dwaddr, a_dwdata}, {26'd0, e_a});
      end
    end
    if (!rst && !c_flush && c_dv && c_dr) begin
      if (q_c.size() == 0) begin
        n_total++;
        $display("FAIL mon_c: got unexpected entry %0h, expected none", c_dwdata);
      end else begin
        e_c = q_c.pop_front();
        chk("mon_c", {26'd0, c_dwen, c_dwaddr, c_dwdata}, {26'd0, e_c});
      end
    end
  end

  task automatic step_a(input logic uv, input logic wen, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic dr, input logic fl);
    a_uv = uv; a_wen = wen; a_waddr = waddr; a_wdata = wdata; a_dr = dr; a_flush = fl;
    @(negedge clk);
    if (fl) q_a.delete();
    else if (uv && a_ur) q_a.push_back(model(wen, waddr, wdata));
    @(posedge clk); #1;
  endtask

  task automatic step_c(input logic uv, input logic wen, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic dr, input logic fl);
    c_uv = uv; c_wen = wen; c_waddr = waddr; c_wdata = wdata; c_dr = dr; c_flush = fl;
    @(negedge clk);
    if (fl) q_c.delete();
    else if (uv && c_ur) q_c.push_back(model(wen, waddr, wdata));
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 1'b0; a_uv = 1'b1; a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 32'h55; a_dr = 1'b1;
    b_flush = 1'b0; b_uv = 1'b1; b_wen = 1'b1; b_waddr = 5'd9; b_wdata = 32'h55; b_dr = 1'b1;
    c_flush = 1'b0; c_uv = 1'b1; c_wen = 1'b1; c_waddr = 5'd9; c_wdata = 32'h55; c_dr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dv", a_dv, 1'b0);
    chk("rst_wen", a_dwen, 1'b0);
    chk("rst_wdata", a_dwdata, 32'h0);
    chk("rst_waddr", a_dwaddr, 5'd0);
    chk("rst_ready", a_ur, 1'b1);
    chk("rst_ready_c", c_ur, 1'b1);
    chk("rst_dv_c", c_dv, 1'b0);
    rst = 1'b0;
    a_uv = 1'b0; b_uv = 1'b0; c_uv = 1'b0;

    // Streaming on A
    step_a(1'b1, 1'b1, 5'd3, 32'h11, 1'b1, 1'b0);
    chk("stream_v0", a_dv, 1'b1); chk("stream_d0", a_dwdata, 32'h11);
    step_a(1'b1, 1'b1, 5'd4, 32'h22, 1'b1, 1'b0);
    chk("stream_v1", a_dv, 1'b1); chk("stream_d1", a_dwdata, 32'h22);
    step_a(1'b1, 1'b1, 5'd5, 32'h33, 1'b1, 1'b0);
    chk("stream_v2", a_dv, 1'b1); chk("stream_d2", a_dwdata, 32'h33);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("stream_drain", a_dv, 1'b0);

    // Backpressure into the skid slot
    step_a(1'b1, 1'b1, 5'd6, 32'hA1, 1'b0, 1'b0);
    chk("bp_ready_one", a_ur, 1'b1); chk("bp_d_a1", a_dwdata, 32'hA1);
    step_a(1'b1, 1'b1, 5'd7, 32'hA2, 1'b0, 1'b0);
    chk("bp_ready_two", a_ur, 1'b0); chk("bp_hold_a1", a_dwdata, 32'hA1);
    step_a(1'b1, 1'b1, 5'd8, 32'hA3, 1'b0, 1'b0);
    chk("bp_stall", a_ur, 1'b0);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("bp_d_a2", a_dwdata, 32'hA2); chk("bp_ready_back", a_ur, 1'b1);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", a_dv, 1'b0);

    // Flush while full, then flush while accepting
    step_a(1'b1, 1'b1, 5'd9, 32'hB1, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 5'd10, 32'hB2, 1'b0, 1'b0);
    chk("fl_two_ready", a_ur, 1'b0);
    step_a(1'b1, 1'b1, 5'd11, 32'hB3, 1'b0, 1'b1);
    chk("fl_dv", a_dv, 1'b0); chk("fl_ready", a_ur, 1'b1);
    step_a(1'b1, 1'b1, 5'd12, 32'hB4, 1'b0, 1'b0);
    step_a(1'b1, 1'b1, 5'd13, 32'hB5, 1'b1, 1'b1);
    chk("fl_one_dv", a_dv, 1'b0);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("fl_stays_empty", a_dv, 1'b0);
    step_a(1'b1, 1'b1, 5'd14, 32'hC1, 1'b1, 1'b0);
    chk("fl_recover", a_dwdata, 32'hC1);

    // Zero squash on A
    step_a(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 1'b0);
    chk("zs_dv", a_dv, 1'b1); chk("zs_wen", a_dwen, 1'b0);
    step_a(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("zs_hold_data", a_dwdata, 32'hDEAD);

    // B: no zero squash, bubble must not write
    b_uv = 1'b1; b_wen = 1'b1; b_waddr = 5'd0; b_wdata = 32'hDEAD; b_dr = 1'b1;
    @(posedge clk); #1;
    b_uv = 1'b0;
    chk("nz_dv", b_dv, 1'b1); chk("nz_wen", b_dwen, 1'b1); chk("nz_data", b_dwdata, 32'hDEAD);
    @(posedge clk); #1;
    chk("nz_bubble_dv", b_dv, 1'b0); chk("nz_bubble_wen", b_dwen, 1'b0);

    // C: single entry with combinational ready
    step_c(1'b1, 1'b1, 5'd1, 32'h51, 1'b0, 1'b0);
    chk("s0_dv", c_dv, 1'b1); chk("s0_d51", c_dwdata, 32'h51);
    c_uv = 1'b1; c_wdata = 32'h52; c_dr = 1'b0; #1;
    chk("s0_ready_low", c_ur, 1'b0);
    c_dr = 1'b1; #1;
    chk("s0_ready_high", c_ur, 1'b1);
    step_c(1'b1, 1'b1, 5'd2, 32'h52, 1'b1, 1'b0);
    chk("s0_replace_v", c_dv, 1'b1); chk("s0_d52", c_dwdata, 32'h52);
    step_c(1'b1, 1'b0, 5'd3, 32'h53, 1'b1, 1'b0);
    chk("s0_d53", c_dwdata, 32'h53); chk("s0_wen0", c_dwen, 1'b0);
    step_c(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("s0_drain", c_dv, 1'b0);

    chk("q_a_empty", q_a.size(), 0);
    chk("q_c_empty", q_c.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
